// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and state type shared by the fetch aligner.
// Exports XLEN, ILEN, HALT_WORD_DEF and state_t.
package fetch_pkg;
   localparam int XLEN = 64;
   localparam int ILEN = 32;
   localparam logic [ILEN-1:0] HALT_WORD_DEF = 32'h0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_EMIT_LO,
      S_EMIT_HI,
      S_HALT
   } state_t;
endpackage

// File: rtl/fetch_aligner_if.sv
// fetch_aligner_if: memory beat port plus decoder handshake.
// master = aligner (mem_req/mem_addr/inst*), slave = memory+decoder.
interface fetch_aligner_if;
   import fetch_pkg::*;

   logic            mem_req;
   logic [XLEN-1:0] mem_addr;
   logic            mem_valid;
   logic [XLEN-1:0] mem_data;
   logic            inst_valid;
   logic            inst_ready;
   logic [ILEN-1:0] inst;
   logic [XLEN-1:0] inst_pc;

   modport master (
      output mem_req, mem_addr,
      input  mem_valid, mem_data,
      output inst_valid, inst, inst_pc,
      input  inst_ready
   );

   modport slave (
      input  mem_req, mem_addr,
      output mem_valid, mem_data,
      input  inst_valid, inst, inst_pc,
      output inst_ready
   );
endinterface

// File: rtl/fetch_aligner.sv
// fetch_aligner: fetches 8-byte beats and presents 32-bit instructions.
// Ports: clk, rst_n, start/start_pc, halted, inst_count, bus (master).
module fetch_aligner
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
   parameter logic [ILEN-1:0] HALT_WORD = HALT_WORD_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [XLEN-1:0] start_pc,
   output logic            halted,
   output logic [31:0]     inst_count,
   fetch_aligner_if.master bus
);

   state_t            state, state_nxt;
   logic [XLEN-1:0]   pc, pc_nxt;
   logic [2*ILEN-1:0] beat, beat_nxt;
   logic [31:0]       cnt, cnt_nxt;
   logic [ILEN-1:0]   half;
   logic              emit;
   logic              at_halt;
   logic              xfer;

   assign emit    = (state == S_EMIT_LO) || (state == S_EMIT_HI);
   assign half    = (state == S_EMIT_HI) ? beat[63:32] : beat[31:0];
   // A halt half is withheld from the decoder and steers to HALT.
   assign at_halt = emit && (half == HALT_WORD);
   assign xfer    = emit && !at_halt && bus.inst_ready;

   assign bus.mem_req    = (state == S_REQ);
   assign bus.mem_addr   = (state == S_REQ) ?
                           {pc[XLEN-1:3], 3'b000} : '0;
   assign bus.inst_valid = emit && !at_halt;
   assign bus.inst       = emit ? half : '0;
   assign bus.inst_pc    = pc;
   assign halted         = (state == S_HALT);
   assign inst_count     = cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         pc    <= RESET_PC;
         beat  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         beat  <= beat_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      beat_nxt  = beat;
      cnt_nxt   = cnt;

      if (xfer) begin
         pc_nxt = pc + 64'd4;
         if (cnt != 32'hFFFF_FFFF)
            cnt_nxt = cnt + 32'd1;
      end

      case (state)
         S_REQ: begin
            if (bus.mem_valid) begin
               beat_nxt  = bus.mem_data;
               // Odd word address: low half lies before pc.
               state_nxt = pc[2] ? S_EMIT_HI : S_EMIT_LO;
            end
         end
         S_EMIT_LO: begin
            if (at_halt)
               state_nxt = S_HALT;
            else if (xfer)
               state_nxt = S_EMIT_HI;
         end
         S_EMIT_HI: begin
            if (at_halt)
               state_nxt = S_HALT;
            else if (xfer)
               state_nxt = S_REQ;
         end
         default: ;
      endcase

      // Restart overrides everything, including a same-cycle transfer.
      if (start) begin
         state_nxt = S_REQ;
         pc_nxt    = start_pc & ~64'd3;
         beat_nxt  = '0;
         cnt_nxt   = '0;
      end
   end

endmodule

// File: tb/tb_fetch_aligner.sv
// tb_fetch_aligner: vector table, corner sequences and random run
// against a program-stream reference model.
module tb_fetch_aligner;
   import fetch_pkg::*;

   localparam logic [63:0] RPC = 64'h8000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [63:0] start_pc = '0;
   logic        halted;
   logic [31:0] inst_count;

   fetch_aligner_if bus();

   always #5 clk = ~clk;

   fetch_aligner #(.RESET_PC(RPC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .start_pc   (start_pc),
      .halted     (halted),
      .inst_count (inst_count),
      .bus        (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [31:0] seed;

   // Synthetic program memory: word at byte address a.
   function automatic logic [31:0] mword(input logic [63:0] a);
      logic [31:0] h;
      h = (a[33:2] * 32'h9E37_79B1) ^ a[63:32] ^ seed;
      h = h ^ (h >> 15);
      if (h[4:0] == 5'd0) return HALT_WORD_DEF;
      return h | 32'h1;
   endfunction

   typedef struct {
      logic [63:0] spc;
      logic [63:0] beat;
      logic [63:0] addr0;
      logic [63:0] pc0;
      logic [31:0] inst0;
      int          xfers;
      logic        halt;
      logic [63:0] nxt;
   } vec_t;

   vec_t vt[6];

   // random-phase model state
   logic [63:0] m_pc;
   logic [31:0] m_cnt;
   bit          m_halt;
   int          wait_cnt;
   int          since;
   bit          prev_stall;
   logic [31:0] prev_inst;
   logic [63:0] prev_pc;
   bit          rdy;
   bit          do_st;
   logic [63:0] spc;

   initial begin
      vt[0] = '{64'h1000, 64'h00000013_00a00093, 64'h1000,
                64'h1000, 32'h00a00093, 2, 1'b0, 64'h1008};
      vt[1] = '{64'h1004, 64'h00000013_00a00093, 64'h1000,
                64'h1004, 32'h00000013, 1, 1'b0, 64'h1008};
      vt[2] = '{64'h1000, 64'h00000000_00b50533, 64'h1000,
                64'h1000, 32'h00b50533, 1, 1'b1, 64'h0};
      vt[3] = '{64'h2000, 64'h00a00093_00000000, 64'h2000,
                64'h0, 32'h0, 0, 1'b1, 64'h0};
      vt[4] = '{64'h1006, 64'h33333333_44444444, 64'h1000,
                64'h1004, 32'h33333333, 1, 1'b0, 64'h1008};
      vt[5] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h11111111_22222222,
                64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC,
                32'h11111111, 1, 1'b0, 64'h0};

      seed = $urandom;
      bus.mem_valid  = 1'b0;
      bus.mem_data   = '0;
      bus.inst_ready = 1'b0;

      // reset values
      @(negedge clk);
      chk("rst_req", 64'(bus.mem_req), 64'd0);
      chk("rst_valid", 64'(bus.inst_valid), 64'd0);
      chk("rst_addr", bus.mem_addr, 64'd0);
      chk("rst_inst", 64'(bus.inst), 64'd0);
      chk("rst_pc", bus.inst_pc, RPC);
      chk("rst_halted", 64'(halted), 64'd0);
      chk("rst_cnt", 64'(inst_count), 64'd0);
      rst_n = 1'b1;
      step();
      chk("idle_req", 64'(bus.mem_req), 64'd0);

      // single-beat vectors
      for (int i = 0; i < 6; i++) begin
         int n;
         int cf;
         int cl;
         n = 0; cf = 0; cl = 0;
         start = 1'b1;
         start_pc = vt[i].spc;
         bus.inst_ready = 1'b1;
         bus.mem_valid = 1'b0;
         step();
         start = 1'b0;
         chk("v_req", 64'(bus.mem_req), 64'd1);
         chk("v_addr0", bus.mem_addr, vt[i].addr0);
         chk("v_cnt0", 64'(inst_count), 64'd0);
         bus.mem_valid = 1'b1;
         bus.mem_data = vt[i].beat;
         step();
         bus.mem_valid = 1'b0;
         chk("v_latency", 64'(bus.inst_valid),
             64'(vt[i].xfers != 0));
         for (int c = 0; c < 6; c++) begin
            if (bus.mem_req || halted) break;
            if (bus.inst_valid) begin
               if (n == 0) begin
                  chk("v_pc0", bus.inst_pc, vt[i].pc0);
                  chk("v_inst0", 64'(bus.inst), 64'(vt[i].inst0));
                  cf = c;
               end
               cl = c;
               n++;
            end
            step();
         end
         chk("v_xfers", 64'(n), 64'(vt[i].xfers));
         if (n > 0)
            chk("v_nobubble", 64'(cl - cf), 64'(n - 1));
         chk("v_halted", 64'(halted), 64'(vt[i].halt));
         chk("v_cnt", 64'(inst_count), 64'(vt[i].xfers));
         if (vt[i].halt) begin
            chk("v_halt_req", 64'(bus.mem_req), 64'd0);
            chk("v_halt_valid", 64'(bus.inst_valid), 64'd0);
         end else begin
            chk("v_next_addr", bus.mem_addr, vt[i].nxt);
         end
      end

      // decoder stall in EMIT_LO
      start = 1'b1;
      start_pc = 64'h3000;
      step();
      start = 1'b0;
      bus.inst_ready = 1'b0;
      bus.mem_valid = 1'b1;
      bus.mem_data = 64'hAAAA0002_BBBB0001;
      step();
      bus.mem_valid = 1'b0;
      repeat (5) begin
         chk("stall_valid", 64'(bus.inst_valid), 64'd1);
         chk("stall_inst", 64'(bus.inst), 64'hBBBB0001);
         chk("stall_pc", bus.inst_pc, 64'h3000);
         chk("stall_cnt", 64'(inst_count), 64'd0);
         step();
      end
      bus.inst_ready = 1'b1;
      step();
      chk("rel_cnt", 64'(inst_count), 64'd1);
      chk("rel_valid", 64'(bus.inst_valid), 64'd1);
      chk("rel_pc", bus.inst_pc, 64'h3004);
      chk("rel_inst", 64'(bus.inst), 64'hAAAA0002);

      // restart during EMIT_HI, together with a transfer
      start = 1'b1;
      start_pc = 64'h1000;
      step();
      start = 1'b0;
      bus.mem_valid = 1'b1;
      bus.mem_data = 64'h00000013_00a00093;
      step();
      bus.mem_valid = 1'b0;
      step();
      chk("abort_hi_pc", bus.inst_pc, 64'h1004);
      chk("abort_hi_valid", 64'(bus.inst_valid), 64'd1);
      start = 1'b1;
      start_pc = 64'h2000;
      step();
      start = 1'b0;
      chk("abort_req", 64'(bus.mem_req), 64'd1);
      chk("abort_addr", bus.mem_addr, 64'h2000);
      chk("abort_cnt", 64'(inst_count), 64'd0);
      chk("abort_valid", 64'(bus.inst_valid), 64'd0);
      step();
      chk("abort_stay_valid", 64'(bus.inst_valid), 64'd0);
      chk("abort_stay_req", 64'(bus.mem_req), 64'd1);

      // asynchronous reset during REQ with mem_valid high
      bus.mem_valid = 1'b1;
      bus.mem_data = 64'h12345678_9ABCDEF1;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_req", 64'(bus.mem_req), 64'd0);
      chk("arst_valid", 64'(bus.inst_valid), 64'd0);
      chk("arst_addr", bus.mem_addr, 64'd0);
      chk("arst_inst", 64'(bus.inst), 64'd0);
      chk("arst_pc", bus.inst_pc, RPC);
      chk("arst_cnt", 64'(inst_count), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      step();
      chk("post_rst_req", 64'(bus.mem_req), 64'd0);
      chk("post_rst_valid", 64'(bus.inst_valid), 64'd0);
      chk("post_rst_pc", bus.inst_pc, RPC);
      chk("post_rst_halted", 64'(halted), 64'd0);
      bus.mem_valid = 1'b0;

      // random run against the program-stream model
      m_pc = '0; m_cnt = '0; m_halt = 1'b0;
      wait_cnt = 0; since = 0; prev_stall = 1'b0;
      prev_inst = '0; prev_pc = '0;
      do_st = 1'b1;
      spc = {$urandom, $urandom};
      m_pc = spc & ~64'd3;
      start = 1'b1;
      start_pc = spc;
      bus.inst_ready = 1'b1;
      step();
      for (int cyc = 0; cyc < 5000; cyc++) begin
         chk("rnd_cnt", 64'(inst_count), 64'(m_cnt));
         if (bus.mem_req)
            chk("rnd_addr", bus.mem_addr, {m_pc[63:3], 3'b000});
         if (bus.inst_valid) begin
            chk("rnd_pc", bus.inst_pc, m_pc);
            chk("rnd_inst", 64'(bus.inst), 64'(mword(m_pc)));
         end
         if (halted) begin
            chk("rnd_halt_word", 64'(mword(m_pc)),
                64'(HALT_WORD_DEF));
            chk("rnd_halt_req", 64'(bus.mem_req), 64'd0);
            m_halt = 1'b1;
         end else if (m_halt) begin
            chk("rnd_halt_hold", 64'(halted), 64'd1);
         end
         if (prev_stall) begin
            chk("rnd_hold_valid", 64'(bus.inst_valid), 64'd1);
            chk("rnd_hold_inst", 64'(bus.inst), 64'(prev_inst));
            chk("rnd_hold_pc", bus.inst_pc, prev_pc);
         end

         rdy = ($urandom_range(0, 3) != 0);
         do_st = ($urandom_range(0, 63) == 0) ||
                 (halted && ($urandom_range(0, 3) == 0));
         if (since > 60) begin
            checks++;
            errors++;
            $display("FAIL rnd_live stuck=%0d limit=60", since);
            do_st = 1'b1;
         end

         if (bus.mem_req) begin
            if (wait_cnt == 0) begin
               bus.mem_valid = 1'b1;
               bus.mem_data = {mword(bus.mem_addr + 64'd4),
                               mword(bus.mem_addr)};
               wait_cnt = $urandom_range(0, 3);
            end else begin
               bus.mem_valid = 1'b0;
               bus.mem_data = {$urandom, $urandom};
               wait_cnt--;
            end
         end else begin
            bus.mem_valid = 1'($urandom_range(0, 1));
            bus.mem_data = {$urandom, $urandom};
         end

         prev_stall = bus.inst_valid && !rdy && !do_st;
         prev_inst = bus.inst;
         prev_pc = bus.inst_pc;
         if (do_st) begin
            spc = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0)
               spc = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255));
            m_pc = spc & ~64'd3;
            m_cnt = '0;
            m_halt = 1'b0;
            since = 0;
         end else if (bus.inst_valid && rdy) begin
            m_pc = m_pc + 64'd4;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            since = 0;
         end else if (!halted) begin
            since++;
         end

         start = do_st;
         start_pc = spc;
         bus.inst_ready = rdy;
         step();
      end
      start = 1'b0;
      bus.mem_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_aligner.md
FETCH_ALIGNER -- requirements
Module: fetch_aligner

Interface
REQ-001 Parameter RESET_PC, default 64'h0: PC loaded at reset.
REQ-002 Parameter HALT_WORD, default 32'h0: instruction value that ends the program.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle pulse that begins fetching at start_pc.
REQ-006 start_pc  input  64  byte address of the first instruction; bits[1:0] ignored.
REQ-007 mem_addr  output  64  8-byte-aligned address of the requested beat.
REQ-008 mem_req  output  1  beat request valid.
REQ-009 mem_valid  input  1  mem_data valid; one beat per request.
REQ-010 mem_data  input  64  beat: bits[31:0] at mem_addr, bits[63:32] at mem_addr+4.
REQ-011 inst_valid  output  1  inst/inst_pc valid to the decoder.
REQ-012 inst_ready  input  1  decoder accepts; transfer when inst_valid && inst_ready.
REQ-013 inst  output  32  instruction word.
REQ-014 inst_pc  output  64  byte address of inst.
REQ-015 halted  output  1  HALT_WORD reached; stays high until start or reset.
REQ-016 inst_count  output  32  instructions transferred since the last start.

Function
REQ-017 States: IDLE, REQ, EMIT_LO, EMIT_HI, HALT.
- IDLE->REQ on start.
- REQ->EMIT_LO on mem_valid when pc[2]=0; REQ->EMIT_HI when pc[2]=1.
- EMIT_LO->EMIT_HI on transfer.
- EMIT_HI->REQ on transfer.
- Any state->HALT when the presented word equals HALT_WORD.
- HALT->REQ on start.
REQ-018 In REQ, mem_req=1 and mem_addr={pc[63:3],3'b000}; the captured beat is held in a 64-bit register.
REQ-019 mem_data is captured on the first cycle with mem_req && mem_valid; mem_valid outside REQ is ignored.
REQ-020 inst = beat[31:0] in EMIT_LO and beat[63:32] in EMIT_HI; inst_pc = pc.
REQ-021 inst_valid=1 in EMIT_LO/EMIT_HI unless the selected half equals HALT_WORD.
REQ-022 pc += 4 on each transfer; the 64-bit add wraps modulo 2^64 without a flag.
REQ-023 A HALT_WORD half is never presented: the block enters HALT in the cycle after the half is selected, with inst_valid=0 and halted=1.
REQ-024 inst, inst_pc and inst_valid hold stable while inst_valid && !inst_ready; there is no bubble between back-to-back transfers from one beat.
REQ-025 Latency: the first inst_valid is asserted one cycle after the mem_valid capture; from start to mem_req is one cycle.
REQ-026 start in any state aborts the current fetch: pc=start_pc, inst_count=0, halted=0, beat discarded, state REQ.
REQ-027 start in the same cycle as a transfer: start wins; the transfer still counts as taken by the decoder and is not re-presented.
REQ-028 inst_count increments per transfer and saturates at 32'hFFFF_FFFF.

Reset
REQ-029 On rst_n low: state=IDLE, pc=RESET_PC, beat=0, inst_count=0, halted=0, mem_req=0, inst_valid=0, mem_addr=0, inst=0, inst_pc=RESET_PC.
REQ-030 Reset asserted mid-operation discards any outstanding beat; a mem_valid arriving after deassertion is ignored in IDLE.

Structure
REQ-031 A shared package fetch_pkg holds the state enum, the XLEN=64 and ILEN=32 constants, and the HALT_WORD default.
REQ-032 Single module with no sub-modules; its output feeds the existing decoder's instruction and PC inputs directly.

Verification
REQ-033 start_pc=0x1000; beat 0x00000013_00a00093, inst_ready=1 -> transfers (0x1000,0x00a00093), then (0x1004,0x00000013); mem_addr=0x1008 on the next request.
REQ-034 start_pc=0x1004 -> first request mem_addr=0x1000; only the high half is emitted, with inst_pc=0x1004.
REQ-035 inst_ready held 0 for 5 cycles in EMIT_LO -> inst and inst_pc stable and inst_count unchanged; one transfer when released.
REQ-036 Beat 0x00000000_00b50533 -> one transfer, then halted=1, inst_valid=0, inst_count=1, mem_req=0.
REQ-037 start pulsed in EMIT_HI with start_pc=0x2000 -> next mem_addr=0x2000 and inst_count=0; the old high half is never presented.
REQ-038 rst_n asserted during REQ with mem_valid high -> all outputs at reset values asynchronously; after deassertion the block stays IDLE.
